mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 20 ++
 rtl/mem_req_arbiter_if.sv | 51 +++++
 rtl/mem_req_arbiter_tag_fifo.sv | 51 +++++
 rtl/mem_req_arbiter.sv | 96 +++++++++
 tb/tb_mem_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-side constants and client identifiers for the request arbiter.
package mem_pkg;

   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int CPU_INST_BITS  = 32;
   localparam int CPU_ADDR_BITS  = 32;
   localparam int WORD_ADDR_BITS = CPU_ADDR_BITS - ceil_log2(CPU_INST_BITS / 8);

   localparam int CLIENT_ID_W = 1;
   typedef logic [CLIENT_ID_W-1:0] client_id_t;
   localparam client_id_t CLIENT_INST = 1'b0;
   localparam client_id_t CLIENT_DATA = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Two client request/response ports plus the downstream memory port of the arbiter.
interface mem_req_arbiter_if #(
   parameter int CPU_WIDTH      = mem_pkg::CPU_INST_BITS,
   parameter int WORD_ADDR_BITS = mem_pkg::WORD_ADDR_BITS
);
   logic                      c0_req_val;
   logic                      c0_req_rdy;
   logic [WORD_ADDR_BITS-1:0] c0_req_addr;
   logic [CPU_WIDTH-1:0]      c0_req_data;
   logic [3:0]                c0_req_write;
   logic                      c0_resp_val;
   logic [CPU_WIDTH-1:0]      c0_resp_data;

   logic                      c1_req_val;
   logic                      c1_req_rdy;
   logic [WORD_ADDR_BITS-1:0] c1_req_addr;
   logic [CPU_WIDTH-1:0]      c1_req_data;
   logic [3:0]                c1_req_write;
   logic                      c1_resp_val;
   logic [CPU_WIDTH-1:0]      c1_resp_data;

   logic                      mem_req_val;
   logic                      mem_req_rdy;
   logic [WORD_ADDR_BITS-1:0] mem_req_addr;
   logic [CPU_WIDTH-1:0]      mem_req_data;
   logic [3:0]                mem_req_write;
   logic                      mem_resp_val;
   logic [CPU_WIDTH-1:0]      mem_resp_data;

   logic                      err_orphan;

   modport slave (
      input  c0_req_val, c0_req_addr, c0_req_data, c0_req_write,
      output c0_req_rdy, c0_resp_val, c0_resp_data,
      input  c1_req_val, c1_req_addr, c1_req_data, c1_req_write,
      output c1_req_rdy, c1_resp_val, c1_resp_data,
      output mem_req_val, mem_req_addr, mem_req_data, mem_req_write,
      input  mem_req_rdy, mem_resp_val, mem_resp_data,
      output err_orphan
   );

   modport master (
      output c0_req_val, c0_req_addr, c0_req_data, c0_req_write,
      input  c0_req_rdy, c0_resp_val, c0_resp_data,
      output c1_req_val, c1_req_addr, c1_req_data, c1_req_write,
      input  c1_req_rdy, c1_resp_val, c1_resp_data,
      input  mem_req_val, mem_req_addr, mem_req_data, mem_req_write,
      output mem_req_rdy, mem_resp_val, mem_resp_data,
      input  err_orphan
   );
endinterface

// File: rtl/mem_req_arbiter_tag_fifo.sv
// Small FIFO of client IDs for outstanding reads; push and pop may coincide even when full.
module tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_din,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of instruction/data clients onto one memory port; read responses
// are steered back by a FIFO of client tags recorded at request time.
module mem_req_arbiter
   import mem_pkg::*;
#(
   parameter int CPU_WIDTH      = CPU_INST_BITS,
   parameter int WORD_ADDR_BITS = mem_pkg::WORD_ADDR_BITS,
   parameter int TAG_DEPTH      = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_req_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   logic [CNT_W-1:0]          w_count;
   logic                      w_full;
   logic                      w_empty;
   client_id_t                w_head;
   client_id_t                r_prio;
   logic                      r_err;

   logic                      w_can_push;
   logic                      w_cand0;
   logic                      w_cand1;
   logic                      w_req_val;
   client_id_t                w_sel;
   logic [WORD_ADDR_BITS-1:0] w_sel_addr;
   logic [CPU_WIDTH-1:0]      w_sel_data;
   logic [3:0]                w_sel_write;
   logic                      w_xfer;
   logic                      w_push;
   logic                      w_pop;

   // A pending response frees a slot in the same cycle, so a full FIFO can still take a read.
   always_comb begin
      w_can_push = !w_full || bus.mem_resp_val;
      w_cand0    = !reset && bus.c0_req_val && ((|bus.c0_req_write) || w_can_push);
      w_cand1    = !reset && bus.c1_req_val && ((|bus.c1_req_write) || w_can_push);
      if (w_cand0 && w_cand1) w_sel = r_prio;
      else if (w_cand1)       w_sel = CLIENT_DATA;
      else                    w_sel = CLIENT_INST;
      w_req_val = w_cand0 || w_cand1;
      if (w_sel == CLIENT_DATA) begin
         w_sel_addr  = bus.c1_req_addr;
         w_sel_data  = bus.c1_req_data;
         w_sel_write = bus.c1_req_write;
      end else begin
         w_sel_addr  = bus.c0_req_addr;
         w_sel_data  = bus.c0_req_data;
         w_sel_write = bus.c0_req_write;
      end
   end

   assign w_xfer = w_req_val && bus.mem_req_rdy;
   assign w_push = w_xfer && (w_sel_write == 4'h0);
   assign w_pop  = !reset && bus.mem_resp_val && !w_empty;

   assign bus.mem_req_val   = w_req_val;
   assign bus.mem_req_addr  = w_sel_addr;
   assign bus.mem_req_data  = w_sel_data;
   assign bus.mem_req_write = w_sel_write;
   assign bus.c0_req_rdy    = bus.mem_req_rdy && w_req_val && (w_sel == CLIENT_INST);
   assign bus.c1_req_rdy    = bus.mem_req_rdy && w_req_val && (w_sel == CLIENT_DATA);

   assign bus.c0_resp_val   = w_pop && (w_head == CLIENT_INST);
   assign bus.c1_resp_val   = w_pop && (w_head == CLIENT_DATA);
   assign bus.c0_resp_data  = bus.mem_resp_data;
   assign bus.c1_resp_data  = bus.mem_resp_data;
   assign bus.err_orphan    = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio <= CLIENT_INST;
         r_err  <= 1'b0;
      end else begin
         if (w_xfer) r_prio <= ~w_sel;
         if (bus.mem_resp_val && w_empty) r_err <= 1'b1;
      end
   end

   tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (CLIENT_ID_W)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_sel),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the arbitration rules.
module tb_mem_req_arbiter;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mem_req_arbiter_if bus ();

   mem_req_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // model state: outstanding read tags in issue order, favoured client, sticky orphan flag
   int tagq[$];
   int prio;
   bit err;
   int e_win;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      reset             = 1'b0;
      bus.c0_req_val    = 1'b0;
      bus.c0_req_addr   = '0;
      bus.c0_req_data   = '0;
      bus.c0_req_write  = 4'h0;
      bus.c1_req_val    = 1'b0;
      bus.c1_req_addr   = '0;
      bus.c1_req_data   = '0;
      bus.c1_req_write  = 4'h0;
      bus.mem_req_rdy   = 1'b1;
      bus.mem_resp_val  = 1'b0;
      bus.mem_resp_data = '0;
   endtask

   task automatic check_cycle();
      bit can_push, a0, a1;
      bit e_rv0, e_rv1;
      #1;
      can_push = (tagq.size() < DEPTH) || bus.mem_resp_val;
      a0 = !reset && bus.c0_req_val && ((bus.c0_req_write != 4'h0) || can_push);
      a1 = !reset && bus.c1_req_val && ((bus.c1_req_write != 4'h0) || can_push);
      if (a0 && a1)  e_win = prio;
      else if (a0)   e_win = 0;
      else if (a1)   e_win = 1;
      else           e_win = -1;
      e_rv0 = !reset && bus.mem_resp_val && (tagq.size() > 0) && (tagq[0] == 0);
      e_rv1 = !reset && bus.mem_resp_val && (tagq.size() > 0) && (tagq[0] == 1);
      chk("c0_req_rdy", bus.c0_req_rdy, bus.mem_req_rdy && e_win == 0);
      chk("c1_req_rdy", bus.c1_req_rdy, bus.mem_req_rdy && e_win == 1);
      chk("mem_req_val", bus.mem_req_val, e_win >= 0);
      if (e_win == 0) begin
         chk("mem_req_addr", bus.mem_req_addr, bus.c0_req_addr);
         chk("mem_req_data", bus.mem_req_data, bus.c0_req_data);
         chk("mem_req_write", bus.mem_req_write, bus.c0_req_write);
      end else if (e_win == 1) begin
         chk("mem_req_addr", bus.mem_req_addr, bus.c1_req_addr);
         chk("mem_req_data", bus.mem_req_data, bus.c1_req_data);
         chk("mem_req_write", bus.mem_req_write, bus.c1_req_write);
      end
      chk("c0_resp_val", bus.c0_resp_val, e_rv0);
      chk("c1_resp_val", bus.c1_resp_val, e_rv1);
      chk("c0_resp_data", bus.c0_resp_data, bus.mem_resp_data);
      chk("c1_resp_data", bus.c1_resp_data, bus.mem_resp_data);
      chk("err_orphan", bus.err_orphan, err);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         tagq.delete();
         prio = 0;
         err  = 1'b0;
      end else begin
         if (bus.mem_resp_val) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else err = 1'b1;
         end
         if (e_win >= 0 && bus.mem_req_rdy) begin
            prio = 1 - e_win;
            if ((e_win == 0 ? bus.c0_req_write : bus.c1_req_write) == 4'h0)
               tagq.push_back(e_win);
         end
      end
   endtask

   task automatic reset_cycle();
      begin_cycle();
      reset = 1'b1;
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      check_cycle();
      chk("rst_mem_req_val", bus.mem_req_val, 1'b0);
      tick();
   endtask

   initial begin
      logic [3:0] pat;
      n_vec = 0;
      n_err = 0;
      tagq.delete();
      prio  = 0;
      err   = 1'b0;
      e_win = -1;

      reset_cycle();
      reset_cycle();
      begin_cycle();
      check_cycle();
      chk("rst_err_orphan", bus.err_orphan, 1'b0);
      chk("rst_count", dut.w_count, 3'd0);
      tick();

      // single read from c0, response one cycle later
      begin_cycle();
      bus.c0_req_val = 1'b1;
      bus.c0_req_addr = 30'h10;
      check_cycle();
      chk("r030_addr", bus.mem_req_addr, 30'h10);
      chk("r030_rdy", bus.c0_req_rdy, 1'b1);
      tick();
      begin_cycle();
      bus.mem_resp_val = 1'b1;
      bus.mem_resp_data = 32'hDEADBEEF;
      check_cycle();
      chk("r030_c0_resp_val", bus.c0_resp_val, 1'b1);
      chk("r030_c0_resp_data", bus.c0_resp_data, 32'hDEADBEEF);
      chk("r030_c1_resp_val", bus.c1_resp_val, 1'b0);
      tick();

      // alternating grants from reset, then FIFO full
      reset_cycle();
      pat = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         begin_cycle();
         bus.c0_req_val = 1'b1;
         bus.c1_req_val = 1'b1;
         bus.c0_req_addr = 30'(i);
         bus.c1_req_addr = 30'(i + 100);
         check_cycle();
         chk("r031_c0_grant", bus.c0_req_rdy, !pat[i]);
         chk("r031_c1_grant", bus.c1_req_rdy, pat[i]);
         tick();
      end
      begin_cycle();
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      check_cycle();
      chk("r032_full_c0_rdy", bus.c0_req_rdy, 1'b0);
      chk("r032_full_c1_rdy", bus.c1_req_rdy, 1'b0);
      chk("r032_full_mem_val", bus.mem_req_val, 1'b0);
      tick();
      begin_cycle();
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      bus.mem_resp_val = 1'b1;
      bus.mem_resp_data = 32'h1111;
      check_cycle();
      chk("r032_pass_c0_rdy", bus.c0_req_rdy, 1'b1);
      chk("r032_pass_c0_resp", bus.c0_resp_val, 1'b1);
      tick();
      begin_cycle();
      check_cycle();
      chk("r032_count", dut.w_count, 3'd4);
      tick();

      // writes bypass a full tag FIFO
      reset_cycle();
      for (int i = 0; i < 4; i++) begin
         begin_cycle();
         bus.c0_req_val = 1'b1;
         bus.c0_req_addr = 30'(i + 8);
         check_cycle();
         chk("r033_read_rdy", bus.c0_req_rdy, 1'b1);
         tick();
      end
      begin_cycle();
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      bus.c1_req_write = 4'hF;
      bus.c1_req_data = 32'hCAFE0001;
      check_cycle();
      chk("r033_write_rdy", bus.c1_req_rdy, 1'b1);
      chk("r033_read_blocked", bus.c0_req_rdy, 1'b0);
      chk("r033_mem_write", bus.mem_req_write, 4'hF);
      tick();
      for (int i = 0; i < 4; i++) begin
         begin_cycle();
         bus.mem_resp_val = 1'b1;
         bus.mem_resp_data = 32'(i + 32'hA0);
         check_cycle();
         chk("r033_c0_resp", bus.c0_resp_val, 1'b1);
         chk("r033_c1_resp", bus.c1_resp_val, 1'b0);
         tick();
      end

      // orphan response with empty FIFO
      begin_cycle();
      bus.mem_resp_val = 1'b1;
      check_cycle();
      chk("r034_c0_resp", bus.c0_resp_val, 1'b0);
      chk("r034_c1_resp", bus.c1_resp_val, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         begin_cycle();
         check_cycle();
         chk("r034_err_sticky", bus.err_orphan, 1'b1);
         tick();
      end
      reset_cycle();
      begin_cycle();
      check_cycle();
      chk("r034_err_cleared", bus.err_orphan, 1'b0);
      tick();

      // reset with reads outstanding
      for (int i = 0; i < 3; i++) begin
         begin_cycle();
         bus.c0_req_val = 1'b1;
         check_cycle();
         tick();
      end
      begin_cycle();
      reset = 1'b1;
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      bus.mem_resp_val = 1'b1;
      check_cycle();
      chk("r035_rst_c0_rdy", bus.c0_req_rdy, 1'b0);
      chk("r035_rst_c1_rdy", bus.c1_req_rdy, 1'b0);
      chk("r035_rst_resp", bus.c0_resp_val, 1'b0);
      tick();
      begin_cycle();
      bus.c0_req_val = 1'b1;
      bus.c1_req_val = 1'b1;
      check_cycle();
      chk("r035_count", dut.w_count, 3'd0);
      chk("r035_grant_c0", bus.c0_req_rdy, 1'b1);
      tick();
      begin_cycle();
      bus.mem_resp_val = 1'b1;
      check_cycle();
      tick();
      begin_cycle();
      bus.mem_resp_val = 1'b1;
      check_cycle();
      tick();
      begin_cycle();
      check_cycle();
      chk("r035_orphan_after", bus.err_orphan, 1'b1);
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         begin_cycle();
         reset = ($urandom_range(0, 99) == 0);
         bus.c0_req_val   = $urandom_range(0, 1);
         bus.c1_req_val   = $urandom_range(0, 1);
         bus.c0_req_addr  = 30'($urandom);
         bus.c1_req_addr  = 30'($urandom);
         bus.c0_req_data  = $urandom;
         bus.c1_req_data  = $urandom;
         bus.c0_req_write = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         bus.c1_req_write = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         bus.mem_req_rdy  = ($urandom_range(0, 3) != 0);
         if (tagq.size() > 0) bus.mem_resp_val = ($urandom_range(0, 9) < 4);
         else                 bus.mem_resp_val = ($urandom_range(0, 39) == 0);
         bus.mem_resp_data = $urandom;
         check_cycle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
